// File: rtl/config_shift_mux_if.sv
// -----------------------------------------------------------------------------
// config_shift_mux_if
//   Bundles the routing data and serial configuration signals of one
//   config_shift_mux instance. Clock and reset stay outside as plain ports.
//
//   Signals:
//     data_in        routing inputs, N_INPUTS wide
//     data_out       selected routing input
//     config_in      serial configuration bit, MSB of the select first
//     config_enable  shift strobe for the configuration chain
//     config_commit  copies the shift register into the active select
//     config_out     serial output towards the next instance in the chain
//     configured     high once a commit has happened since reset
//
//   Modports:
//     master  drives data_in and the config strobes (fabric / bench side)
//     slave   the multiplexer itself
// -----------------------------------------------------------------------------
interface config_shift_mux_if #(
  parameter int N_INPUTS = 6
);
  logic [N_INPUTS-1:0] data_in;
  logic                data_out;
  logic                config_in;
  logic                config_enable;
  logic                config_commit;
  logic                config_out;
  logic                configured;

  modport master (
    output data_in,
    output config_in,
    output config_enable,
    output config_commit,
    input  data_out,
    input  config_out,
    input  configured
  );

  modport slave (
    input  data_in,
    input  config_in,
    input  config_enable,
    input  config_commit,
    output data_out,
    output config_out,
    output configured
  );
endinterface

// File: rtl/config_shift_mux.sv
// -----------------------------------------------------------------------------
// config_shift_mux
//   N:1 routing multiplexer with its own serial configuration chain.
//   A SEL_WIDTH-bit shift register is loaded one bit per enabled clock,
//   MSB first, and a commit strobe copies it into the active select so the
//   route changes atomically. Select codes at or above N_INPUTS, and any
//   select before the first commit, route a constant 0.
//
//   Ports:
//     clock  rising-edge fabric/config clock
//     reset  asynchronous, active-high reset
//     bus    config_shift_mux_if.slave (data_in, data_out, config_in,
//            config_enable, config_commit, config_out, configured)
//
//   Parameters:
//     N_INPUTS    number of routing inputs (>= 2)
//     SEL_WIDTH   select width and length of this instance's config chain
//     REGISTERED  1: data_out registered (latency 1); 0: combinational
// -----------------------------------------------------------------------------
module config_shift_mux #(
  parameter int N_INPUTS   = 6,
  parameter int SEL_WIDTH  = $clog2(N_INPUTS),
  parameter bit REGISTERED = 1'b0
) (
  input logic               clock,
  input logic               reset,
  config_shift_mux_if.slave bus
);

  logic [SEL_WIDTH-1:0] sr_q;
  logic [SEL_WIDTH-1:0] sr_d;
  logic [SEL_WIDTH-1:0] act_q;
  logic [SEL_WIDTH-1:0] act_d;
  logic                 configured_q;
  logic                 configured_d;
  logic                 sel_val_s;

  // Shift register next state: one new bit enters at the LSB per enabled edge.
  generate
    if (SEL_WIDTH == 1) begin : g_sr_single
      always_comb begin
        sr_d = sr_q;
        if (bus.config_enable) begin
          sr_d = bus.config_in;
        end else begin
          sr_d = sr_q;
        end
      end
    end else begin : g_sr_multi
      always_comb begin
        sr_d = sr_q;
        if (bus.config_enable) begin
          sr_d = {sr_q[SEL_WIDTH-2:0], bus.config_in};
        end else begin
          sr_d = sr_q;
        end
      end
    end
  endgenerate

  // Commit next state: act samples the pre-shift sr_q, so a shift on the
  // same edge does not leak into the committed select.
  always_comb begin
    act_d        = act_q;
    configured_d = configured_q;
    if (bus.config_commit) begin
      act_d        = sr_q;
      configured_d = 1'b1;
    end else begin
      act_d        = act_q;
      configured_d = configured_q;
    end
  end

  // Configuration state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr_q         <= {SEL_WIDTH{1'b0}};
      act_q        <= {SEL_WIDTH{1'b0}};
      configured_q <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      act_q        <= act_d;
      configured_q <= configured_d;
    end
  end

  // Explicit one-hot decode: codes with no matching input contribute nothing,
  // which gives the zero-padded behaviour without an out-of-range index.
  always_comb begin
    sel_val_s = 1'b0;
    for (int i = 0; i < N_INPUTS; i++) begin
      sel_val_s = sel_val_s |
                  (configured_q & (act_q == SEL_WIDTH'(i)) & bus.data_in[i]);
    end
  end

  generate
    if (REGISTERED) begin : g_out_reg
      logic out_q;

      // Pipelined routing stage.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          out_q <= 1'b0;
        end else begin
          out_q <= sel_val_s;
        end
      end

      assign bus.data_out = out_q;
    end else begin : g_out_comb
      assign bus.data_out = sel_val_s;
    end
  endgenerate

  assign bus.config_out = sr_q[SEL_WIDTH-1];
  assign bus.configured = configured_q;

endmodule

// File: tb/tb_config_shift_mux.sv
// -----------------------------------------------------------------------------
// tb_config_shift_mux
//   Directed bench for config_shift_mux (N_INPUTS=6, SEL_WIDTH=3).
//   u_a: combinational output, head of a two-instance chain.
//   u_b: combinational output, config_in fed from u_a.config_out.
//   u_r: registered output.
//   Expected values are pushed to a scoreboard queue when stimulus is applied
//   and popped when the corresponding output is sampled.
// -----------------------------------------------------------------------------
module tb_config_shift_mux;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  config_shift_mux_if #(.N_INPUTS(6)) if_a ();
  config_shift_mux_if #(.N_INPUTS(6)) if_b ();
  config_shift_mux_if #(.N_INPUTS(6)) if_r ();

  config_shift_mux #(.N_INPUTS(6), .SEL_WIDTH(3), .REGISTERED(1'b0)) u_a (
    .clock(clock), .reset(reset), .bus(if_a)
  );
  config_shift_mux #(.N_INPUTS(6), .SEL_WIDTH(3), .REGISTERED(1'b0)) u_b (
    .clock(clock), .reset(reset), .bus(if_b)
  );
  config_shift_mux #(.N_INPUTS(6), .SEL_WIDTH(3), .REGISTERED(1'b1)) u_r (
    .clock(clock), .reset(reset), .bus(if_r)
  );

  assign if_b.config_in = if_a.config_out;

  typedef struct {
    string tag;
    logic  exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic push(input string tag, input logic exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic obs);
    sb_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty: observed %b, nothing expected", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic exp_now(input string tag, input logic obs, input logic exp);
    push(tag, exp);
    check(obs);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic a_shift(input logic b);
    if_a.config_in     = b;
    if_a.config_enable = 1'b1;
    tick();
    if_a.config_enable = 1'b0;
  endtask

  task automatic a_commit();
    if_a.config_commit = 1'b1;
    tick();
    if_a.config_commit = 1'b0;
  endtask

  task automatic a_load3(input logic [2:0] v);
    a_shift(v[2]);
    a_shift(v[1]);
    a_shift(v[0]);
  endtask

  task automatic r_shift(input logic b);
    if_r.config_in     = b;
    if_r.config_enable = 1'b1;
    tick();
    if_r.config_enable = 1'b0;
  endtask

  task automatic r_commit();
    if_r.config_commit = 1'b1;
    tick();
    if_r.config_commit = 1'b0;
  endtask

  logic [5:0] chain_bits;

  initial begin
    reset              = 1'b1;
    if_a.data_in       = 6'b111111;
    if_a.config_in     = 1'b0;
    if_a.config_enable = 1'b0;
    if_a.config_commit = 1'b0;
    if_b.data_in       = 6'b000000;
    if_b.config_enable = 1'b0;
    if_b.config_commit = 1'b0;
    if_r.data_in       = 6'b000000;
    if_r.config_in     = 1'b0;
    if_r.config_enable = 1'b0;
    if_r.config_commit = 1'b0;

    // Reset state.
    #2;
    exp_now("rst_data_out",   if_a.data_out,   1'b0);
    exp_now("rst_config_out", if_a.config_out, 1'b0);
    exp_now("rst_configured", if_a.configured, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Idle after reset with every input high.
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_now("idle_data_out",   if_a.data_out,   1'b0);
      exp_now("idle_configured", if_a.configured, 1'b0);
      exp_now("idle_config_out", if_a.config_out, 1'b0);
    end

    // Load select 4; before commit the output is forced low.
    a_load3(3'd4);
    if_a.data_in = 6'b010001;
    #1;
    exp_now("precommit_data_out",   if_a.data_out,   1'b0);
    exp_now("precommit_configured", if_a.configured, 1'b0);
    if_a.data_in = 6'b010000;
    a_commit();
    exp_now("sel4_data_out",   if_a.data_out,   1'b1);
    exp_now("sel4_configured", if_a.configured, 1'b1);
    if_a.data_in = 6'b000000;
    #1;
    exp_now("sel4_comb_low", if_a.data_out, 1'b0);
    if_a.data_in = 6'b010000;

    // Shifting 1,1,1 must not disturb the active route; then commit code 7.
    for (int i = 0; i < 3; i++) begin
      a_shift(1'b1);
      exp_now("shift_stable", if_a.data_out, 1'b1);
    end
    exp_now("sr7_config_out", if_a.config_out, 1'b1);
    a_commit();
    if_a.data_in = 6'b111111;
    #1;
    exp_now("sel7_zero", if_a.data_out, 1'b0);

    // Code 5 follows data_in[5].
    a_load3(3'd5);
    a_commit();
    if_a.data_in = 6'b100000;
    #1;
    exp_now("sel5_high", if_a.data_out, 1'b1);
    if_a.data_in = 6'b011111;
    #1;
    exp_now("sel5_low", if_a.data_out, 1'b0);

    // Simultaneous enable+commit with sr=3 and config_in=1.
    a_load3(3'd3);
    if_a.data_in = 6'b100000;
    #1;
    exp_now("load3_act_held",    if_a.data_out,   1'b1);
    exp_now("load3_config_out",  if_a.config_out, 1'b0);
    if_a.config_in     = 1'b1;
    if_a.config_enable = 1'b1;
    if_a.config_commit = 1'b1;
    tick();
    if_a.config_enable = 1'b0;
    if_a.config_commit = 1'b0;
    exp_now("both_old_sel_gone", if_a.data_out, 1'b0);
    if_a.data_in = 6'b001000;
    #1;
    exp_now("both_act3",        if_a.data_out,   1'b1);
    exp_now("both_sr7_msb",     if_a.config_out, 1'b1);
    a_commit();
    if_a.data_in = 6'b111111;
    #1;
    exp_now("both_sr7_commit", if_a.data_out, 1'b0);

    // Reset in the middle of a load.
    a_load3(3'd2);
    a_commit();
    if_a.data_in = 6'b000100;
    #1;
    exp_now("sel2_before_rst", if_a.data_out, 1'b1);
    a_shift(1'b1);
    a_shift(1'b0);
    #2;
    reset = 1'b1;
    #1;
    exp_now("midrst_data_out",   if_a.data_out,   1'b0);
    exp_now("midrst_configured", if_a.configured, 1'b0);
    exp_now("midrst_config_out", if_a.config_out, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    a_shift(1'b0);
    exp_now("partial_lost", if_a.config_out, 1'b0);
    a_shift(1'b0);
    a_shift(1'b1);
    a_commit();
    if_a.data_in = 6'b000010;
    #1;
    exp_now("reload_sel1",       if_a.data_out,   1'b1);
    exp_now("reload_configured", if_a.configured, 1'b1);
    if_a.data_in = 6'b111101;
    #1;
    exp_now("reload_sel1_low", if_a.data_out, 1'b0);

    // Two-instance chain: A.config_out feeds B.config_in.
    #2;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chain_bits = 6'b010011;
    for (int j = 1; j <= 6; j++) begin
      if_a.config_in     = chain_bits[6-j];
      if_a.config_enable = 1'b1;
      if_b.config_enable = 1'b1;
      tick();
      push("chain_a_msb", (j >= 3) ? chain_bits[8-j] : 1'b0);
      check(if_a.config_out);
    end
    if_a.config_enable = 1'b0;
    if_b.config_enable = 1'b0;
    if_a.config_commit = 1'b1;
    if_b.config_commit = 1'b1;
    tick();
    if_a.config_commit = 1'b0;
    if_b.config_commit = 1'b0;
    if_a.data_in = 6'b001000;
    if_b.data_in = 6'b000100;
    #1;
    exp_now("chain_a_act3", if_a.data_out, 1'b1);
    exp_now("chain_b_act2", if_b.data_out, 1'b1);
    if_a.data_in = 6'b110111;
    if_b.data_in = 6'b111011;
    #1;
    exp_now("chain_a_act3_low", if_a.data_out, 1'b0);
    exp_now("chain_b_act2_low", if_b.data_out, 1'b0);

    // Registered output: set act=2 with data_in=100100.
    if_r.data_in = 6'b100100;
    r_shift(1'b0);
    r_shift(1'b1);
    r_shift(1'b0);
    exp_now("reg_unconfigured", if_r.data_out, 1'b0);
    r_commit();
    exp_now("reg_first_commit_lat", if_r.data_out, 1'b0);
    tick();
    exp_now("reg_act2", if_r.data_out, 1'b1);

    // Shift in 5 while act=2, commit: stays high throughout.
    r_shift(1'b1);
    exp_now("reg_shift_hold", if_r.data_out, 1'b1);
    r_shift(1'b0);
    exp_now("reg_shift_hold", if_r.data_out, 1'b1);
    r_shift(1'b1);
    exp_now("reg_shift_hold", if_r.data_out, 1'b1);
    r_commit();
    exp_now("reg_commit_old", if_r.data_out, 1'b1);
    tick();
    exp_now("reg_act5", if_r.data_out, 1'b1);

    // data_in[5] toggles appear one edge later.
    if_r.data_in = 6'b000100;
    push("reg_lat_hold", 1'b1);
    push("reg_lat_fall", 1'b0);
    #1;
    check(if_r.data_out);
    tick();
    check(if_r.data_out);
    if_r.data_in = 6'b100100;
    push("reg_lat_rise", 1'b1);
    tick();
    check(if_r.data_out);

    // Old selection visible for one cycle after commit: 5 -> 2 with only input 5 high.
    r_shift(1'b0);
    r_shift(1'b1);
    r_shift(1'b0);
    if_r.data_in = 6'b100000;
    tick();
    exp_now("reg_pre_switch", if_r.data_out, 1'b1);
    r_commit();
    exp_now("reg_switch_old", if_r.data_out, 1'b1);
    tick();
    exp_now("reg_switch_new", if_r.data_out, 1'b0);

    // Asynchronous reset clears the registered output immediately.
    if_r.data_in = 6'b000100;
    tick();
    exp_now("reg_before_rst", if_r.data_out, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    exp_now("reg_rst_data_out",   if_r.data_out,   1'b0);
    exp_now("reg_rst_configured", if_r.configured, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    n_cmp++;
    assert (sb_q.size() == 0) else begin
      n_err++;
      $error("FAIL sb_leftover: observed %0d entries expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/config_shift_mux.md
Name: config_shift_mux

Overview:
- Parametrised N:1 routing multiplexer for the FPGA fabric, with its own serial configuration chain.
- A shift register loads the select value one bit per clock. A separate commit strobe copies it into the active select, so the routing changes atomically.
- Instances chain through config_in/config_out to form the bitstream path of a tile.
- Optional output register supports pipelined routing. Select values at or above N drive 0, as in the zero-padded mux tree.

Parameters:
- N_INPUTS, 6, number of data inputs (>=2)
- SEL_WIDTH, $clog2(N_INPUTS), width of the select field and length of the config chain (>=1)
- REGISTERED, 0, 1 = data_out registered (latency 1); 0 = combinational output

Ports:
- clock  input  1  fabric/config clock, rising edge
- reset  input  1  asynchronous, active-high reset
- data_in  input  N_INPUTS  routing inputs
- data_out  output  1  selected input
- config_in  input  1  serial config bit, MSB of select first
- config_enable  input  1  shift strobe for the config chain
- config_commit  input  1  copies the shift register into the active select
- config_out  output  1  serial output to the next instance in the chain
- configured  output  1  high once at least one commit has occurred since reset

Behaviour:
- Reset (async, active-high) clears:
  - shift register sr[SEL_WIDTH-1:0] = 0
  - active select act = 0
  - configured = 0
  - output register (if REGISTERED) = 0
  - data_out = 0 and config_out = 0 while reset is asserted
- Shift:
  - On a rising edge with config_enable=1: sr <= {sr[SEL_WIDTH-2:0], config_in}. For SEL_WIDTH=1: sr <= config_in.
  - config_out = sr[SEL_WIDTH-1], a registered output (no combinational path from config_in).
  - A full load takes SEL_WIDTH enabled edges, MSB first. Cascaded chain length = sum of SEL_WIDTH over all instances.
  - config_enable=0: sr holds.
- Commit:
  - On a rising edge with config_commit=1: act <= sr and configured <= 1.
  - If config_enable and config_commit are both high on the same edge, commit captures the pre-shift sr. The shift still occurs.
  - Commit with no prior shift after reset loads act = 0.
  - Shifting never disturbs act; routing stays stable during reconfiguration.
- Select:
  - sel_val = data_in[act] if act < N_INPUTS, else 0.
  - configured = 0 forces sel_val = 0.
- Output:
  - REGISTERED=0: data_out = sel_val, combinational from data_in and act.
  - REGISTERED=1: data_out <= sel_val every edge, latency 1. The first cycle after a commit still shows the old selection; the new selection appears on the next edge.
- Reset mid-load: partial shift contents are lost. configured drops, and data_out returns to 0 immediately (async, both modes).
- No X propagation: every register is reset. Unused select codes are decoded explicitly to 0.

Test Plan (N_INPUTS=6, SEL_WIDTH=3 unless stated):
- Reset then idle, data_in=6'b111111 -> data_out=0, configured=0, config_out=0 for 10 cycles.
- Shift 1,0,0 (act target 4), commit, data_in=6'b010000 -> REGISTERED=0: data_out=1 in the cycle after commit, configured=1. Set data_in[4]=0 -> data_out=0 the same cycle.
- Shift 1,1,1 (select 7 >= N), commit, data_in=6'b111111 -> data_out=0. Repeat with select 5 -> data_out follows data_in[5].
- Two instances chained (A.config_out -> B.config_in), 6 enabled shifts of 0,1,0, 0,1,1, then commit -> B.act=2 (first three bits shifted through), A.act=3. config_out of A shows A's sr MSB one edge after each shift.
- REGISTERED=1, act=2, then shift in 5 and commit while data_in=6'b100100 -> data_out=1 before and one cycle after commit, then still 1 (input 5 high). Toggle data_in[5] -> data_out follows with 1-cycle latency.
- Simultaneous enable+commit with sr=3, config_in=1 -> act=3, sr=7. Assert reset mid-shift (after 2 bits) -> configured=0, data_out=0 asynchronously. After release, a fresh 3-bit load and commit works correctly.
